// File: rtl/demux_1x16_deser_pkg.sv
// Shared definitions for the serial-to-parallel word deserializer.
// Holds the state encoding and the default geometry shared with mux-side blocks.
package demux_1x16_deser_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_SEL_W = $clog2(DEFAULT_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_HOLD    = 2'd2,
    ST_UNUSED  = 2'd3
  } state_t;

endpackage

// File: rtl/demux_1x16_deser_bit_index_counter.sv
// Beat index counter: modulo-2^SEL_W, clear beats increment, tc flags index WIDTH-1.
// Latency: count updates on the edge after inc/clr; tc is combinational from count.
// Backpressure: none; the caller gates inc with its own accept condition.
module bit_index_counter #(
  parameter int WIDTH = 16,
  parameter int SEL_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [SEL_W-1:0] count,
  output logic             tc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == SEL_W'(WIDTH - 1));

endmodule

// File: rtl/demux_1x16_deser.sv
// Serial-to-parallel deserializer: one bit per accepted beat into a WIDTH-bit word.
// Latency: word and data_valid appear on the edge that accepts the last beat.
// Backpressure: bit_ready drops while a finished word waits; data_ready releases it.
module demux_1x16_deser
  import demux_1x16_deser_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int SEL_W     = $clog2(WIDTH),
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             bit_ready,
  output logic [SEL_W-1:0] select_out,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready
);

  state_t             state_q;
  state_t             state_d;
  logic [WIDTH-1:0]   asm_q;
  logic [WIDTH-1:0]   asm_d;
  logic [WIDTH-1:0]   asm_bit;
  logic [WIDTH-1:0]   data_out_d;
  logic               data_valid_d;
  logic               bit_ready_d;
  logic [SEL_W-1:0]   idx;
  logic [SEL_W-1:0]   map_idx;
  logic               idx_tc;
  logic               accept;
  logic               clear_eff;
  logic               cnt_clr;

  assign accept    = bit_valid & bit_ready & (state_q == ST_COLLECT);
  assign clear_eff = clear & ((state_q == ST_COLLECT) | (state_q == ST_HOLD));
  assign map_idx   = MSB_FIRST ? (SEL_W'(WIDTH - 1) - idx) : idx;

  always_comb begin
    asm_bit          = asm_q;
    asm_bit[map_idx] = bit_in;
  end

  // Index also returns to 0 on an illegal state so the frame restarts cleanly.
  assign cnt_clr = clear_eff | (state_q == ST_UNUSED);

  bit_index_counter #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_idx (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (accept & ~clear_eff),
    .clr   (cnt_clr),
    .count (idx),
    .tc    (idx_tc)
  );

  assign select_out = idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_COLLECT;
      ST_COLLECT: begin
        if (!clear && accept && idx_tc) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (clear || data_ready) begin
          state_d = ST_COLLECT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    asm_d        = asm_q;
    data_out_d   = data_out;
    data_valid_d = data_valid;
    bit_ready_d  = bit_ready;
    case (state_q)
      ST_IDLE: begin
        bit_ready_d  = 1'b1;
        data_valid_d = 1'b0;
      end
      ST_COLLECT: begin
        if (clear) begin
          asm_d       = '0;
          bit_ready_d = 1'b1;
        end else if (accept) begin
          asm_d = asm_bit;
          if (idx_tc) begin
            data_out_d   = asm_bit;
            data_valid_d = 1'b1;
            bit_ready_d  = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        // clear drops the unread word but leaves data_out as last seen.
        if (clear) begin
          asm_d        = '0;
          data_valid_d = 1'b0;
          bit_ready_d  = 1'b1;
        end else if (data_ready) begin
          data_valid_d = 1'b0;
          bit_ready_d  = 1'b1;
        end
      end
      default: begin
        asm_d        = '0;
        data_valid_d = 1'b0;
        bit_ready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      asm_q      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      bit_ready  <= 1'b0;
    end else begin
      asm_q      <= asm_d;
      data_out   <= data_out_d;
      data_valid <= data_valid_d;
      bit_ready  <= bit_ready_d;
    end
  end

endmodule

// File: tb/tb_demux_1x16_deser.sv
// Directed bench for demux_1x16_deser: LSB-first and MSB-first instances share stimulus.
module tb_demux_1x16_deser;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear;
  logic        bit_in;
  logic        bit_valid;
  logic        data_ready;
  logic        bit_ready, bit_ready_m;
  logic [3:0]  select_out, select_out_m;
  logic [15:0] data_out, data_out_m;
  logic        data_valid, data_valid_m;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  demux_1x16_deser #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready),
    .select_out (select_out),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready)
  );

  demux_1x16_deser #(.WIDTH(16), .SEL_W(4), .MSB_FIRST(1'b1)) dut_msb (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_ready  (bit_ready_m),
    .select_out (select_out_m),
    .data_out   (data_out_m),
    .data_valid (data_valid_m),
    .data_ready (data_ready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge; return at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  logic [15:0] word;

  initial begin
    rst_n      = 1'b0;
    clear      = 1'b0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    data_ready = 1'b0;
    repeat (3) step();

    chk("rst_bit_ready", 32'(bit_ready), 32'd0);
    chk("rst_data_valid", 32'(data_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_select", 32'(select_out), 32'd0);

    rst_n = 1'b1;
    chk("idle_bit_ready", 32'(bit_ready), 32'd0);
    step();
    chk("post_idle_bit_ready", 32'(bit_ready), 32'd1);

    // Round trip: 16'hABAB, one beat per cycle, also checks the MSB-first copy.
    word      = 16'b1010101110101011;
    bit_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("rt_select_%0d", k), 32'(select_out), 32'(k));
      if (k == 15) chk("rt_valid_early", 32'(data_valid), 32'd0);
      bit_in = word[k];
      step();
    end
    chk("rt_data_valid", 32'(data_valid), 32'd1);
    chk("rt_data_out", 32'(data_out), 32'hABAB);
    chk("rt_msb_data_out", 32'(data_out_m), 32'hD5D5);
    chk("rt_msb_data_valid", 32'(data_valid_m), 32'd1);
    chk("rt_bit_ready", 32'(bit_ready), 32'd0);
    chk("rt_select_wrap", 32'(select_out), 32'd0);

    // Backpressure: bits offered while holding are ignored.
    bit_in = 1'b1;
    repeat (5) step();
    chk("bp_data_valid", 32'(data_valid), 32'd1);
    chk("bp_data_out", 32'(data_out), 32'hABAB);
    chk("bp_bit_ready", 32'(bit_ready), 32'd0);
    chk("bp_select", 32'(select_out), 32'd0);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;
    chk("hs_data_valid", 32'(data_valid), 32'd0);
    chk("hs_bit_ready", 32'(bit_ready), 32'd1);
    chk("hs_select", 32'(select_out), 32'd0);
    chk("hs_data_out_kept", 32'(data_out), 32'hABAB);

    // Gaps: valid toggles 1/0, junk on bit_in during idle beats.
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("gap_select_%0d", k), 32'(select_out), 32'(k));
      bit_valid = 1'b1;
      bit_in    = (k == 0);
      step();
      bit_valid = 1'b0;
      bit_in    = 1'b1;
      step();
    end
    chk("gap_data_valid", 32'(data_valid), 32'd1);
    chk("gap_data_out", 32'(data_out), 32'h0001);
    data_ready = 1'b1;
    step();
    data_ready = 1'b0;

    // Clear mid-frame after 7 beats; clear wins over a simultaneous accept.
    bit_valid = 1'b1;
    bit_in    = 1'b0;
    repeat (7) step();
    chk("clr_pre_select", 32'(select_out), 32'd7);
    clear  = 1'b1;
    bit_in = 1'b1;
    step();
    clear = 1'b0;
    chk("clr_select", 32'(select_out), 32'd0);
    chk("clr_bit_ready", 32'(bit_ready), 32'd1);
    for (int k = 0; k < 16; k++) begin
      if (k == 15) chk("clr_valid_early", 32'(data_valid), 32'd0);
      step();
    end
    chk("clr_data_valid", 32'(data_valid), 32'd1);
    chk("clr_data_out", 32'(data_out), 32'hFFFF);

    // Clear in HOLD drops the word but keeps data_out.
    bit_valid = 1'b0;
    clear     = 1'b1;
    step();
    clear = 1'b0;
    chk("hclr_data_valid", 32'(data_valid), 32'd0);
    chk("hclr_data_out", 32'(data_out), 32'hFFFF);
    chk("hclr_bit_ready", 32'(bit_ready), 32'd1);
    chk("hclr_select", 32'(select_out), 32'd0);

    // Asynchronous reset mid-frame.
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    repeat (3) step();
    chk("mid_select", 32'(select_out), 32'd3);
    bit_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("arst_select", 32'(select_out), 32'd0);
    chk("arst_bit_ready", 32'(bit_ready), 32'd0);
    chk("arst_data_out", 32'(data_out), 32'd0);
    chk("arst_data_valid", 32'(data_valid), 32'd0);
    step();
    rst_n = 1'b1;
    chk("arst_idle_ready", 32'(bit_ready), 32'd0);
    step();
    chk("arst_post_ready", 32'(bit_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
